branch_sequencer: RTL and testbench

Control-side driver for the conditional-branch path: on each decoded branch instruction it steps the datapath through the register-read, condition-capture and PC-update phases. It produces the `CON_enable` strobe and `IR_C2` select that the condition flip-flop consumes, reads back its `Q`, and gates `PCin` so that the target is loaded only when the condition holds. It sits between instruction decode and the bus/register control lines, in parallel with the main control unit's T0–T2 fetch steps.

---
 rtl/branch_sequencer_pkg.sv | 28 ++
 rtl/branch_sequencer.sv | 90 +++++++++
 tb/tb_branch_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared control definitions for the conditional-branch sequencer: state codes,
// instruction-register field positions and condition-select code names.
package branch_sequencer_pkg;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_T3A  = 6'b000010,
    S_T3B  = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int C2_HI = 20;
  localparam int C2_LO = 19;
  localparam int C_HI  = 18;
  localparam int C_LO  = 0;

  typedef enum logic [1:0] {
    EQZ = 2'b00,
    NEZ = 2'b01,
    GEZ = 2'b10,
    LTZ = 2'b11
  } c2_t;

endpackage

// File: rtl/branch_sequencer.sv
// Steps the datapath through Ra read, condition capture and PC update for a
// conditional branch; every control output is a flop decoded from the next state.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            hold,
  input  logic [BITS-1:0] ir,
  input  logic            con_q,
  output logic [1:0]      IR_C2,
  output logic            CON_enable,
  output logic            gra,
  output logic            rout,
  output logic            pc_out,
  output logic            y_in,
  output logic            c_out,
  output logic            alu_add,
  output logic            z_in,
  output logic            zlow_out,
  output logic            pc_in,
  output logic            busy,
  output logic            taken
);

  state_t state_reg;
  state_t state_next;

  // Only the condition-select field is consumed here; the rest of IR feeds the datapath.
  logic ir_unused;
  assign ir_unused = ^ir;

  always_comb begin
    state_next = state_reg;
    if (!hold) begin
      unique case (state_reg)
        S_IDLE:  state_next = start ? S_T3A : S_IDLE;
        S_T3A:   state_next = S_T3B;
        S_T3B:   state_next = S_T4;
        S_T4:    state_next = S_T5;
        S_T5:    state_next = S_T6;
        S_T6:    state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= S_IDLE;
      IR_C2      <= 2'b00;
      CON_enable <= 1'b0;
      gra        <= 1'b0;
      rout       <= 1'b0;
      pc_out     <= 1'b0;
      y_in       <= 1'b0;
      c_out      <= 1'b0;
      alu_add    <= 1'b0;
      z_in       <= 1'b0;
      zlow_out   <= 1'b0;
      pc_in      <= 1'b0;
      busy       <= 1'b0;
      taken      <= 1'b0;
    end else if (!hold) begin
      state_reg  <= state_next;
      if (state_reg == S_IDLE && start) begin
        IR_C2 <= ir[C2_HI:C2_LO];
      end
      gra        <= (state_next == S_T3A) || (state_next == S_T3B);
      rout       <= (state_next == S_T3A) || (state_next == S_T3B);
      CON_enable <= (state_next == S_T3B);
      pc_out     <= (state_next == S_T4);
      y_in       <= (state_next == S_T4);
      c_out      <= (state_next == S_T5);
      alu_add    <= (state_next == S_T5);
      z_in       <= (state_next == S_T5);
      zlow_out   <= (state_next == S_T6);
      // The condition FF has been stable since capture, so it is read as T6 is entered.
      pc_in      <= (state_next == S_T6) && con_q;
      busy       <= (state_next != S_IDLE);
      if (state_next == S_T6) begin
        taken <= con_q;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a step-count model checked every cycle,
// a condition-FF stub, and literal per-branch expectations.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        hold;
  logic [31:0] ir;
  logic        con_q;
  logic [1:0]  IR_C2;
  logic        CON_enable, gra, rout, pc_out, y_in, c_out, alu_add, z_in;
  logic        zlow_out, pc_in, busy, taken;

  logic [31:0] ra_bus;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.BITS(32)) dut (
    .clk(clk), .clr(clr), .start(start), .hold(hold), .ir(ir), .con_q(con_q),
    .IR_C2(IR_C2), .CON_enable(CON_enable), .gra(gra), .rout(rout),
    .pc_out(pc_out), .y_in(y_in), .c_out(c_out), .alu_add(alu_add),
    .z_in(z_in), .zlow_out(zlow_out), .pc_in(pc_in), .busy(busy), .taken(taken)
  );

  // Condition flip-flop stub: evaluates the selected condition on the bus value.
  function automatic logic cond_eval(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      2'b00:   return (v == 32'd0);
      2'b01:   return (v != 32'd0);
      2'b10:   return !v[31];
      default: return v[31];
    endcase
  endfunction

  always @(posedge CON_enable or posedge clr) begin
    if (clr) con_q <= 1'b0;
    else     con_q <= cond_eval(IR_C2, ra_bus);
  end

  // Model: phase = number of unstalled cycles since the branch was accepted (0 = idle).
  int         m_phase = 0;
  logic [1:0] m_c2    = 2'b00;
  logic       m_cond  = 1'b0;
  logic       m_taken = 1'b0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_phase = 0; m_c2 = 2'b00; m_cond = 1'b0; m_taken = 1'b0;
    end else if (!hold) begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1;
          m_c2    = ir[20:19];
        end
      end else begin
        m_phase = (m_phase == 5) ? 0 : m_phase + 1;
        if (m_phase == 5) begin
          m_cond  = con_q;
          m_taken = con_q;
        end
      end
    end
  end

  function automatic logic [13:0] model_vec();
    logic [13:0] v;
    v = {m_c2,
         m_phase == 2,
         m_phase == 1 || m_phase == 2,
         m_phase == 1 || m_phase == 2,
         m_phase == 3, m_phase == 3,
         m_phase == 4, m_phase == 4, m_phase == 4,
         m_phase == 5,
         m_phase == 5 && m_cond,
         m_phase != 0,
         m_taken};
    return v;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {IR_C2, CON_enable, gra, rout, pc_out, y_in, c_out, alu_add, z_in,
            zlow_out, pc_in, busy, taken};
  endfunction

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    compared = compared + 1;
    if (dut_vec() !== model_vec()) begin
      failed = failed + 1;
      $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, dut_vec(), model_vec());
    end
  end

  // Running totals for the literal checks.
  int busy_tot = 0, conhi_tot = 0, pcin_tot = 0, zlow_tot = 0, rise_tot = 0;
  always @(negedge clk) begin
    if (busy)       busy_tot  = busy_tot + 1;
    if (CON_enable) conhi_tot = conhi_tot + 1;
    if (pc_in)      pcin_tot  = pcin_tot + 1;
    if (zlow_out)   zlow_tot  = zlow_tot + 1;
  end
  always @(posedge CON_enable) rise_tot = rise_tot + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared = compared + 1;
    if (act !== req) begin
      failed = failed + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int b0, c0, p0, z0, r0;

  task automatic snap();
    b0 = busy_tot; c0 = conhi_tot; p0 = pcin_tot; z0 = zlow_tot; r0 = rise_tot;
  endtask

  // One branch; returns with the sequencer back in IDLE.
  task automatic run_branch(input logic [1:0] c2, input logic [31:0] ra,
                            input int hold_cycles, input bit poke);
    ir        = 32'h1234_5678;
    ir[20:19] = c2;
    ra_bus    = ra;
    start     = 1'b1;
    step();                 // T3A
    start = 1'b0;
    step();                 // T3B
    if (hold_cycles > 0) begin
      hold = 1'b1;
      repeat (hold_cycles) step();
      hold = 1'b0;
    end
    step();                 // T4
    if (poke) begin
      start     = 1'b1;
      ir[20:19] = 2'b11;
    end
    step();                 // T5
    start = 1'b0;
    step();                 // T6
    step();                 // IDLE
    $display("branch c2=%b ra=%h hold=%0d -> IR_C2=%b taken=%b", c2, ra, hold_cycles, IR_C2, taken);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; hold = 1'b0; ir = 32'd0; ra_bus = 32'd0;
    #3;
    check("reset_outputs", {18'd0, dut_vec()}, 32'd0);
    step(); step();
    clr = 1'b0;
    step();

    // Taken brzr
    snap();
    run_branch(2'b00, 32'd0, 0, 1'b0);
    check("brzr_busy_cycles", busy_tot - b0, 5);
    check("brzr_con_rises",   rise_tot - r0, 1);
    check("brzr_con_high",    conhi_tot - c0, 1);
    check("brzr_pc_in",       pcin_tot - p0, 1);
    check("brzr_taken",       taken, 1);

    // Not-taken brnz
    snap();
    run_branch(2'b01, 32'd0, 0, 1'b0);
    check("brnz_con_rises", rise_tot - r0, 1);
    check("brnz_pc_in",     pcin_tot - p0, 0);
    check("brnz_zlow",      zlow_tot - z0, 1);
    check("brnz_taken",     taken, 0);

    // Stall in T3B
    snap();
    run_branch(2'b00, 32'd0, 3, 1'b0);
    check("stall_con_high",  conhi_tot - c0, 4);
    check("stall_con_rises", rise_tot - r0, 1);
    check("stall_busy",      busy_tot - b0, 8);
    check("stall_taken",     taken, 1);

    // Start during T4 with C2 changed: ignored, C2 stays latched
    snap();
    run_branch(2'b10, 32'h7FFF_FFFF, 0, 1'b1);
    check("poke_ir_c2",     IR_C2, 2'b10);
    check("poke_busy",      busy_tot - b0, 5);
    check("poke_con_rises", rise_tot - r0, 1);
    check("poke_taken",     taken, 1);

    // Back-to-back brmi, negative Ra
    snap();
    run_branch(2'b11, 32'h8000_0000, 0, 1'b0);
    check("brmi_neg_busy",  busy_tot - b0, 5);
    check("brmi_neg_taken", taken, 1);

    // Reset mid-T4 aborts the sequence
    snap();
    ir = 32'd0; ir[20:19] = 2'b00; ra_bus = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();         // T4
    check("pre_reset_pc_out", pc_out, 1);
    #1 clr = 1'b1;
    #1;
    check("midreset_outputs", {18'd0, dut_vec()}, 32'd0);
    step();
    clr = 1'b0;
    repeat (4) step();
    check("midreset_pc_in", pcin_tot - p0, 0);
    check("midreset_busy",  busy, 0);

    // brmi, non-negative Ra
    snap();
    run_branch(2'b11, 32'h7FFF_FFFF, 0, 1'b0);
    check("brmi_pos_pc_in", pcin_tot - p0, 0);
    check("brmi_pos_taken", taken, 0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
